// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl
//   Select sequencer for a downstream 16:1 single-bit mux. It steps the mux
//   select through channels 0..15. On each enabled channel it waits SETTLE
//   extra cycles, then samples the mux output. The 16 samples form one frame,
//   which is offered on a valid/ready handshake.
//
// Parameters:
//   SETTLE       extra cycles sel is held before sampling an enabled channel
//                (0..255)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        scan request, only honoured in IDLE
//   chan_mask    per-channel enable, latched when start is accepted
//   mux_in       output of the downstream mux (depends combinationally on sel)
//   sel          select driven to the mux
//   frame        assembled scan result, bit n = channel n
//   frame_valid  frame available (DONE state)
//   frame_ready  consumer accepts frame
//   busy         high while scanning or holding a frame
//
// Configuration macro:
//   MUX16_SCAN_AUTO_EN  when defined, a completed handshake restarts the scan
//                       with the held mask instead of returning to IDLE.

module mux16_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] chan_mask,
  input  logic        mux_in,
  output logic [3:0]  sel,
  output logic [15:0] frame,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        busy
);

  // The dwell counter only has to count up to SETTLE. It keeps at least one bit.
  localparam int              DW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [DW-1:0]   SETTLE_Q = DW'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    mask_q;
  logic [3:0]     ch;
  logic [DW-1:0]  dwell;
  logic           chan_last;

  // A masked channel takes exactly one cycle. An enabled channel ends on
  // the cycle in which the dwell counter has reached SETTLE.
  assign chan_last = !mask_q[ch] || (dwell == SETTLE_Q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Channel 15 is detected explicitly, so ch never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (chan_last && (ch == 4'd15)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (frame_ready) begin
`ifdef MUX16_SCAN_AUTO_EN
          state_nxt = SCAN;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: mask latch, channel/dwell counters and frame assembly.
  // The sample is taken only at the edge that ends a channel. That edge comes
  // after sel has been stable for SETTLE+1 cycles. A masked channel simply
  // contributes a zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 16'h0000;
      ch     <= 4'd0;
      dwell  <= '0;
      frame  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= chan_mask;
            ch     <= 4'd0;
            dwell  <= '0;
            frame  <= 16'h0000;
          end
        end
        SCAN: begin
          if (chan_last) begin
            frame[ch] <= mask_q[ch] & mux_in;
            dwell     <= '0;
            if (ch != 4'd15) begin
              ch <= ch + 4'd1;
            end
          end else if (dwell != SETTLE_Q) begin
            dwell <= dwell + DW'(1);
          end
        end
        DONE: begin
`ifdef MUX16_SCAN_AUTO_EN
          if (frame_ready) begin
            ch    <= 4'd0;
            dwell <= '0;
            frame <= 16'h0000;
          end
`endif
        end
        default: begin
          ch    <= 4'd0;
          dwell <= '0;
        end
      endcase
    end
  end

  // Output decode. In DONE, ch rests at 15, so sel stays frozen on the last channel.
  always_comb begin
    sel         = 4'd0;
    busy        = 1'b0;
    frame_valid = 1'b0;
    case (state)
      SCAN: begin
        sel  = ch;
        busy = 1'b1;
      end
      DONE: begin
        sel         = ch;
        busy        = 1'b1;
        frame_valid = 1'b1;
      end
      default: begin
        sel         = 4'd0;
        busy        = 1'b0;
        frame_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl
//   Directed testbench for mux16_scan_ctrl. A behavioural 16:1 mux is driven
//   from muxWord and indexed by the DUT's sel. Expected frames, latencies and
//   per-channel dwell times are worked out from the mask and SETTLE.
//
// Configuration macro:
//   MUX16_SCAN_AUTO_EN  exercises the auto-restart build with SETTLE=0.

module tb_mux16_scan_ctrl;

`ifdef MUX16_SCAN_AUTO_EN
  localparam int TbSettle = 0;
`else
  localparam int TbSettle = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] chan_mask = 16'h0000;
  logic        mux_in;
  logic [3:0]  sel;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        busy;

  logic [15:0] muxWord = 16'h0000;
  int          checkCount = 0;
  int          passCount = 0;
  int          selCount [16];
  int          busyLow = 0;
  int          latency;

  always #5 clk = ~clk;

  // Behavioural model of the downstream combinational mux
  assign mux_in = muxWord[sel];

  mux16_scan_ctrl #(
    .SETTLE(TbSettle)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chan_mask  (chan_mask),
    .mux_in     (mux_in),
    .sel        (sel),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy       (busy)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from the start accept edge to frame_valid
  function automatic int expLatency(input logic [15:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += m[i] ? (TbSettle + 1) : 1;
    end
    return n;
  endfunction

  // Drive one scan request through the accept edge. Afterwards chan_mask is
  // scrambled, which shows that the latched mask is the one in use.
  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] w,
                               input logic rdy, input logic holdStart);
    chan_mask   = m;
    muxWord     = w;
    frame_ready = rdy;
    start       = 1'b1;
    @(posedge clk);
    #1;
    if (!holdStart) begin
      start = 1'b0;
    end
    chan_mask = ~m;
  endtask

  // Wait (bounded) for frame_valid and record how long sel sits on each channel
  task automatic waitFrame(output int cycles);
    for (int i = 0; i < 16; i++) begin
      selCount[i] = 0;
    end
    busyLow = 0;
    cycles  = 0;
    while (!frame_valid && cycles < 400) begin
      selCount[sel]++;
      if (!busy) begin
        busyLow++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic checkDwell(input logic [15:0] m);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("dwell_ch%0d", i), selCount[i], m[i] ? (TbSettle + 1) : 1);
    end
  endtask

  initial begin
    $display("[TB] start, SETTLE=%0d", TbSettle);

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_frame", frame, 16'h0000);
    checkOutput("rst_valid", frame_valid, 0);
    checkOutput("rst_busy", busy, 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef MUX16_SCAN_AUTO_EN
    // First frame started by start. Later frames restart on their own.
    applyStimulus(16'h0001, 16'h0001, 1'b1, 1'b0);
    waitFrame(latency);
    checkOutput("auto1_latency", latency, expLatency(16'h0001));
    checkOutput("auto1_frame", frame, 16'h0001);
    muxWord = 16'h0000;
    @(posedge clk);
    #1;
    checkOutput("auto_restart_busy", busy, 1);
    checkOutput("auto_restart_valid", frame_valid, 0);
    checkOutput("auto_restart_frame", frame, 16'h0000);
    waitFrame(latency);
    checkOutput("auto2_latency", latency, 16);
    checkOutput("auto2_frame", frame, 16'h0000);
    checkOutput("auto2_busy_low", busyLow, 0);
    muxWord = 16'h0001;
    @(posedge clk);
    #1;
    waitFrame(latency);
    checkOutput("auto3_latency", latency, 16);
    checkOutput("auto3_frame", frame, 16'h0001);
    checkOutput("auto3_busy_low", busyLow, 0);
    // Backpressure holds the frame even in auto mode
    frame_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("auto_hold_valid", frame_valid, 1);
    checkOutput("auto_hold_frame", frame, 16'h0001);
`else
    // frame_ready without frame_valid does nothing
    frame_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_ready_busy", busy, 0);
    checkOutput("idle_ready_valid", frame_valid, 0);

    // Full scan. Ready is already high when valid rises, so transfer is immediate.
    applyStimulus(16'hFFFF, 16'hA5C3, 1'b1, 1'b0);
    waitFrame(latency);
    checkOutput("full_latency", latency, 48);
    checkOutput("full_frame", frame, 16'hA5C3);
    checkOutput("full_sel_done", sel, 15);
    checkOutput("full_busy_done", busy, 1);
    checkDwell(16'hFFFF);
    @(posedge clk);
    #1;
    checkOutput("full_valid_drop", frame_valid, 0);
    checkOutput("full_busy_idle", busy, 0);
    checkOutput("full_sel_idle", sel, 0);
    checkOutput("full_frame_held", frame, 16'hA5C3);

    // Masked scan. start is held high the whole time and must be ignored.
    applyStimulus(16'h00F0, 16'hFFFF, 1'b1, 1'b1);
    waitFrame(latency);
    start = 1'b0;
    checkOutput("mask_latency", latency, 24);
    checkOutput("mask_frame", frame, 16'h00F0);
    checkDwell(16'h00F0);
    @(posedge clk);
    #1;
    checkOutput("mask_valid_drop", frame_valid, 0);

    // Empty mask: one cycle per channel and an all-zero frame
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    waitFrame(latency);
    checkOutput("zero_latency", latency, expLatency(16'h0000));
    checkOutput("zero_frame", frame, 16'h0000);
    @(posedge clk);
    #1;

    // Backpressure: the frame is held for 10 cycles, and a start pulse meanwhile is dropped
    applyStimulus(16'h0F0F, 16'h3C3C, 1'b0, 1'b0);
    waitFrame(latency);
    checkOutput("bp_latency", latency, 32);
    checkOutput("bp_frame", frame, 16'h0C0C);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1;
      end
      if (k == 4) begin
        start = 1'b0;
      end
      muxWord = ~muxWord;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold_valid%0d", k), frame_valid, 1);
      checkOutput($sformatf("bp_hold_frame%0d", k), frame, 16'h0C0C);
      checkOutput($sformatf("bp_hold_sel%0d", k), sel, 15);
    end
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_valid_drop", frame_valid, 0);
    checkOutput("bp_busy_idle", busy, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_no_queued_start", busy, 0);

    // Reset in the middle of channel 7 throws the partial frame away
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    latency = 0;
    while (sel != 4'd7 && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
    end
    checkOutput("mid_reached_ch7", sel, 7);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_sel", sel, 0);
    checkOutput("mid_rst_frame", frame, 16'h0000);
    checkOutput("mid_rst_valid", frame_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_idle_busy", busy, 0);
    applyStimulus(16'hFFFF, 16'h1234, 1'b1, 1'b0);
    waitFrame(latency);
    checkOutput("mid_new_latency", latency, 48);
    checkOutput("mid_new_frame", frame, 16'h1234);
    @(posedge clk);
    #1;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
